// File: rtl/dmux_pkg.sv
// Shared definitions for the dmux_dispatch single-word dispatcher:
// buffer state encoding and default geometry.
package dmux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_DEST_W  = 2;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/rr_pointer.sv
// Round-robin destination pointer: steps through 0..NUM_OUT-1 on each
// advance and wraps back to 0.
module rr_pointer
  import dmux_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int PTR_W   = DEF_DEST_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_OUT - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // next pointer value
  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      if (ptr_q == LAST) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dmux_dispatch.sv
// One-word buffered demultiplexer: captures a producer word and offers it to
// a single consumer chosen by in_dest (directed) or a round-robin pointer.
module dmux_dispatch
  import dmux_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DEST_W  = DEF_DEST_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [DEST_W-1:0]  in_dest,
  input  logic               cfg_rr,
  input  logic               flush,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               err_dest,
  output logic [CNT_W-1:0]   disp_count
);

  localparam logic [DEST_W:0] NUM_OUT_L = (DEST_W + 1)'(NUM_OUT);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [DEST_W-1:0]  dest_q, dest_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               full_s;
  logic               sel_ready_s;
  logic               in_ready_s;
  logic               hs_s;
  logic               cap_s;
  logic               dest_bad_s;
  logic               keep_s;
  logic [DEST_W-1:0]  cap_dest_s;
  logic [DEST_W-1:0]  rr_ptr_s;
  logic               rr_adv_s;
  logic [NUM_OUT-1:0] out_valid_s;

  rr_pointer #(
    .NUM_OUT (NUM_OUT),
    .PTR_W   (DEST_W)
  ) u_rr_pointer (
    .clk   (clk),
    .reset (reset),
    .adv   (rr_adv_s),
    .ptr   (rr_ptr_s)
  );

  // handshake qualification; in_ready follows the selected consumer while FULL
  always_comb begin
    full_s      = (state_q == ST_FULL);
    sel_ready_s = out_ready[dest_q];
    if (flush) begin
      in_ready_s = 1'b0;
    end else if (full_s) begin
      in_ready_s = sel_ready_s;
    end else begin
      in_ready_s = 1'b1;
    end
    hs_s       = full_s && sel_ready_s && !flush;
    cap_s      = in_valid && in_ready_s;
    cap_dest_s = cfg_rr ? rr_ptr_s : in_dest;
    dest_bad_s = !cfg_rr && ({1'b0, in_dest} >= NUM_OUT_L);
    keep_s     = cap_s && !dest_bad_s;
    rr_adv_s   = cap_s && cfg_rr;
  end

  // next-state and datapath
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    err_d   = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_EMPTY: begin
        if (keep_s) state_d = ST_FULL;
        else        state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (flush)     state_d = ST_EMPTY;
        else if (hs_s) state_d = keep_s ? ST_FULL : ST_EMPTY;
        else           state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (keep_s) begin
      data_d = in_data;
      dest_d = cap_dest_s;
    end else begin
      data_d = data_q;
      dest_d = dest_q;
    end
    // an out-of-range directed word is swallowed and only reported
    if (cap_s && dest_bad_s) err_d = 1'b1;
    else                     err_d = 1'b0;
    if (hs_s) count_d = count_q + CNT_W'(1);
    else      count_d = count_q;
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      dest_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // one-hot offer to the buffered word's consumer
  always_comb begin
    if (full_s) out_valid_s = NUM_OUT'(1) << dest_q;
    else        out_valid_s = '0;
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_s;
  assign out_data   = data_q;
  assign err_dest   = err_q;
  assign disp_count = count_q;

endmodule
